// File: rtl/core_pkg.sv
// Shared definitions for the RISC-V core front end: default widths and
// vectors, the PC unit state encoding and the redirect-source encoding.
package core_pkg;

  localparam int          CORE_XLEN         = 32;
  localparam logic [31:0] CORE_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] CORE_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          CORE_IALIGN_BITS  = 2;

  // BOOT: first cycle out of reset, no fetch issued yet.
  // RUN:  fetching, no redirect waiting.
  // PEND: fetching, a redirect is parked in the buffer until the PC can move.
  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } pc_state_t;

  // Which redirect request (if any) won arbitration this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_JUMP,
    SRC_BRANCH
  } redirect_src_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer. Holds a jump/branch target that arrived
// while the PC could not advance. A new capture overwrites the old entry.
// The alignment check is done on the stored target so the PC unit can decide
// between applying it and vectoring to the trap handler.
module pc_redirect_buf
  import core_pkg::*;
#(
  parameter int XLEN        = CORE_XLEN,
  parameter int IALIGN_BITS = CORE_IALIGN_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic            clear,
  input  logic [XLEN-1:0] target_in,
  output logic            valid,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << IALIGN_BITS) - 64'd1);

  // Capture wins over clear so a redirect raised in the same cycle as a
  // clear request is never dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (capture) begin
      valid  <= 1'b1;
      target <= target_in;
    end else if (clear) begin
      valid  <= 1'b0;
    end
  end

  assign misaligned = valid && ((target & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the 32-bit RISC-V core. Drives the fetch address,
// handles the fetch-ready/stall handshake, buffers redirects that arrive
// while blocked, and performs trap entry / mret return through an internal
// EPC. Redirect targets are checked for alignment when applied.
module pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN         = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(CORE_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(CORE_TRAP_VECTOR),
  parameter int              IALIGN_BITS  = CORE_IALIGN_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_curr,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] epc,
  output logic            misalign_fault
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << IALIGN_BITS) - 64'd1);

  pc_state_t       state;
  redirect_src_t   redirect_src;
  logic [XLEN-1:0] redirect_target;
  logic            new_redirect;
  logic            redirect_misaligned;

  logic            running;
  logic            advance;
  logic            override;

  logic            buf_capture;
  logic            buf_clear;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic            pend_misaligned;

  logic            apply_redirect;
  logic [XLEN-1:0] apply_target;
  logic            apply_misaligned;

  assign pc_plus4 = pc_curr + XLEN'(4);

  assign running  = (state != BOOT);
  assign advance  = fetch_valid && fetch_ready && !stall;
  assign override = trap_req || mret;

  // Arbitrate between the two redirect sources; a jump always beats a
  // taken branch presented in the same cycle.
  always_comb begin
    redirect_src    = SRC_NONE;
    redirect_target = '0;
    if (jump) begin
      redirect_src    = SRC_JUMP;
      redirect_target = jump_target;
    end else if (PCSrc) begin
      redirect_src    = SRC_BRANCH;
      redirect_target = branch_target;
    end
  end

  assign new_redirect        = (redirect_src != SRC_NONE);
  assign redirect_misaligned = (redirect_target & ALIGN_MASK) != '0;

  // Park the redirect when the PC cannot move; drop the entry whenever the
  // PC moves (a fresh redirect supersedes it, otherwise it is applied now)
  // or when a trap/mret takes control of the PC.
  assign buf_capture = running && new_redirect && !advance && !override;
  assign buf_clear   = running && (override || advance);

  pc_redirect_buf #(
    .XLEN        (XLEN),
    .IALIGN_BITS (IALIGN_BITS)
  ) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .capture    (buf_capture),
    .clear      (buf_clear),
    .target_in  (redirect_target),
    .valid      (pend_valid),
    .target     (pend_target),
    .misaligned (pend_misaligned)
  );

  // A redirect reaches the PC only on advance; a live request outranks the
  // buffered one.
  assign apply_redirect   = running && !override && advance && (new_redirect || pend_valid);
  assign apply_target     = new_redirect ? redirect_target : pend_target;
  assign apply_misaligned = new_redirect ? redirect_misaligned : pend_misaligned;

  // Main PC state machine: trap > mret > redirect > pending > sequential.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= BOOT;
      pc_curr        <= RESET_VECTOR;
      epc            <= '0;
      fetch_valid    <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      misalign_fault <= 1'b0;
      if (state == BOOT) begin
        state       <= RUN;
        fetch_valid <= 1'b1;
      end else if (trap_req) begin
        epc     <= pc_curr;
        pc_curr <= TRAP_VECTOR;
        state   <= RUN;
      end else if (mret) begin
        pc_curr <= epc;
        state   <= RUN;
      end else if (apply_redirect) begin
        state <= RUN;
        if (apply_misaligned) begin
          epc            <= pc_curr;
          pc_curr        <= TRAP_VECTOR;
          misalign_fault <= 1'b1;
        end else begin
          pc_curr <= apply_target;
        end
      end else if (buf_capture) begin
        state <= PEND;
      end else if (advance) begin
        pc_curr <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit. Each scenario task queues stimulus rows
// and their expected post-edge results, then plays them and compares.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_curr;
  logic [31:0] pc_plus4;
  logic        jump;
  logic [31:0] jump_target;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        trap_req;
  logic        mret;
  logic [31:0] epc;
  logic        misalign_fault;

  // ctl = {reset, stall, fetch_ready, jump, PCSrc, trap_req, mret}
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] jt;
    logic [31:0] bt;
  } stim_t;

  // flags = {fetch_valid, misalign_fault}
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [1:0]  flags;
    logic [31:0] epc;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc_curr        (pc_curr),
    .pc_plus4       (pc_plus4),
    .jump           (jump),
    .jump_target    (jump_target),
    .PCSrc          (PCSrc),
    .branch_target  (branch_target),
    .trap_req       (trap_req),
    .mret           (mret),
    .epc            (epc),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one stimulus row and the state expected after the next edge.
  task automatic add(input string tag, input logic [6:0] ctl, input logic [31:0] jt,
                     input logic [31:0] bt, input logic [31:0] pc, input logic [1:0] flags,
                     input logic [31:0] ep);
    stim_t s;
    exp_t  e;
    s.ctl = ctl; s.jt = jt; s.bt = bt;
    e.tag = tag; e.pc = pc; e.flags = flags; e.epc = ep;
    stim_q.push_back(s);
    sb_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    reset         = s.ctl[6];
    stall         = s.ctl[5];
    fetch_ready   = s.ctl[4];
    jump          = s.ctl[3];
    PCSrc         = s.ctl[2];
    trap_req      = s.ctl[1];
    mret          = s.ctl[0];
    jump_target   = s.jt;
    branch_target = s.bt;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    add("reset0",  7'b0_0_1_0_0_0_0, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    add("reset1",  7'b0_0_1_0_0_0_0, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    add("boot",    7'b1_0_1_0_0_0_0, 32'h0, 32'h0, 32'h0, 2'b10, 32'h0);
    add("seq4",    7'b1_0_1_0_0_0_0, 32'h0, 32'h0, 32'h4, 2'b10, 32'h0);
    add("seq8",    7'b1_0_1_0_0_0_0, 32'h0, 32'h0, 32'h8, 2'b10, 32'h0);
    add("seqC",    7'b1_0_1_0_0_0_0, 32'h0, 32'h0, 32'hC, 2'b10, 32'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (pc_curr !== e.pc) begin errors++; $display("[TB] FAIL %s pc_curr got %h expected %h", e.tag, pc_curr, e.pc); end
      checks++; if (pc_plus4 !== e.pc + 32'd4) begin errors++; $display("[TB] FAIL %s pc_plus4 got %h expected %h", e.tag, pc_plus4, e.pc + 32'd4); end
      checks++; if (fetch_valid !== e.flags[1]) begin errors++; $display("[TB] FAIL %s fetch_valid got %b expected %b", e.tag, fetch_valid, e.flags[1]); end
      checks++; if (misalign_fault !== e.flags[0]) begin errors++; $display("[TB] FAIL %s misalign_fault got %b expected %b", e.tag, misalign_fault, e.flags[0]); end
      checks++; if (epc !== e.epc) begin errors++; $display("[TB] FAIL %s epc got %h expected %h", e.tag, epc, e.epc); end
    end
  endtask

  task automatic test_redirect();
    stim_t s;
    exp_t  e;
    add("jmp40",    7'b1_0_1_1_0_0_0, 32'h40,  32'h0,  32'h40,  2'b10, 32'h0);
    add("jmpbeats", 7'b1_0_1_1_1_0_0, 32'h200, 32'h80, 32'h200, 2'b10, 32'h0);
    add("branch",   7'b1_0_1_0_1_0_0, 32'h0,   32'h80, 32'h80,  2'b10, 32'h0);
    add("seq84",    7'b1_0_1_0_0_0_0, 32'h0,   32'h0,  32'h84,  2'b10, 32'h0);
    add("notready", 7'b1_0_0_0_0_0_0, 32'h0,   32'h0,  32'h84,  2'b10, 32'h0);
    add("stalled",  7'b1_1_1_0_0_0_0, 32'h0,   32'h0,  32'h84,  2'b10, 32'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (pc_curr !== e.pc) begin errors++; $display("[TB] FAIL %s pc_curr got %h expected %h", e.tag, pc_curr, e.pc); end
      checks++; if (fetch_valid !== e.flags[1]) begin errors++; $display("[TB] FAIL %s fetch_valid got %b expected %b", e.tag, fetch_valid, e.flags[1]); end
      checks++; if (misalign_fault !== e.flags[0]) begin errors++; $display("[TB] FAIL %s misalign_fault got %b expected %b", e.tag, misalign_fault, e.flags[0]); end
      checks++; if (epc !== e.epc) begin errors++; $display("[TB] FAIL %s epc got %h expected %h", e.tag, epc, e.epc); end
    end
  endtask

  task automatic test_pending();
    stim_t s;
    exp_t  e;
    add("jmp10",     7'b1_0_1_1_0_0_0, 32'h10,  32'h0,   32'h10,  2'b10, 32'h0);
    add("capt300",   7'b1_1_1_0_1_0_0, 32'h0,   32'h300, 32'h10,  2'b10, 32'h0);
    add("hold2",     7'b1_1_1_0_0_0_0, 32'h0,   32'h0,   32'h10,  2'b10, 32'h0);
    add("hold3",     7'b1_1_1_0_0_0_0, 32'h0,   32'h0,   32'h10,  2'b10, 32'h0);
    add("apply300",  7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h300, 2'b10, 32'h0);
    add("seq304",    7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h304, 2'b10, 32'h0);
    add("capt400",   7'b1_1_1_0_1_0_0, 32'h0,   32'h400, 32'h304, 2'b10, 32'h0);
    add("over500",   7'b1_1_1_1_0_0_0, 32'h500, 32'h0,   32'h304, 2'b10, 32'h0);
    add("apply500",  7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h500, 2'b10, 32'h0);
    add("nrdy600",   7'b1_0_0_1_0_0_0, 32'h600, 32'h0,   32'h500, 2'b10, 32'h0);
    add("apply600",  7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h600, 2'b10, 32'h0);
    add("capt700",   7'b1_1_1_0_1_0_0, 32'h0,   32'h700, 32'h600, 2'b10, 32'h0);
    add("live800",   7'b1_0_1_1_0_0_0, 32'h800, 32'h0,   32'h800, 2'b10, 32'h0);
    add("discard",   7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h804, 2'b10, 32'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (pc_curr !== e.pc) begin errors++; $display("[TB] FAIL %s pc_curr got %h expected %h", e.tag, pc_curr, e.pc); end
      checks++; if (fetch_valid !== e.flags[1]) begin errors++; $display("[TB] FAIL %s fetch_valid got %b expected %b", e.tag, fetch_valid, e.flags[1]); end
      checks++; if (misalign_fault !== e.flags[0]) begin errors++; $display("[TB] FAIL %s misalign_fault got %b expected %b", e.tag, misalign_fault, e.flags[0]); end
    end
  endtask

  task automatic test_trap_mret();
    stim_t s;
    exp_t  e;
    add("jmp24",     7'b1_0_1_1_0_0_0, 32'h24, 32'h0,   32'h24,  2'b10, 32'h0);
    add("capt900",   7'b1_1_1_0_1_0_0, 32'h0,  32'h900, 32'h24,  2'b10, 32'h0);
    add("trapstall", 7'b1_1_1_0_0_1_0, 32'h0,  32'h0,   32'h100, 2'b10, 32'h24);
    add("pendgone",  7'b1_0_1_0_0_0_0, 32'h0,  32'h0,   32'h104, 2'b10, 32'h24);
    add("seq108",    7'b1_0_1_0_0_0_0, 32'h0,  32'h0,   32'h108, 2'b10, 32'h24);
    add("mret",      7'b1_0_1_0_0_0_1, 32'h0,  32'h0,   32'h24,  2'b10, 32'h24);
    add("trapmret",  7'b1_0_1_0_0_1_1, 32'h0,  32'h0,   32'h100, 2'b10, 32'h24);
    add("mret2",     7'b1_0_1_0_0_0_1, 32'h0,  32'h0,   32'h24,  2'b10, 32'h24);
    add("seq28",     7'b1_0_1_0_0_0_0, 32'h0,  32'h0,   32'h28,  2'b10, 32'h24);
    add("trap28",    7'b1_1_1_1_0_1_0, 32'h80, 32'h0,   32'h100, 2'b10, 32'h28);
    add("mretblk",   7'b1_1_0_0_0_0_1, 32'h0,  32'h0,   32'h28,  2'b10, 32'h28);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (pc_curr !== e.pc) begin errors++; $display("[TB] FAIL %s pc_curr got %h expected %h", e.tag, pc_curr, e.pc); end
      checks++; if (misalign_fault !== e.flags[0]) begin errors++; $display("[TB] FAIL %s misalign_fault got %b expected %b", e.tag, misalign_fault, e.flags[0]); end
      checks++; if (epc !== e.epc) begin errors++; $display("[TB] FAIL %s epc got %h expected %h", e.tag, epc, e.epc); end
    end
  endtask

  task automatic test_misalign();
    stim_t s;
    exp_t  e;
    add("jmp50",     7'b1_0_1_1_0_0_0, 32'h50,  32'h0,   32'h50,  2'b10, 32'h28);
    add("jmp202",    7'b1_0_1_1_0_0_0, 32'h202, 32'h0,   32'h100, 2'b11, 32'h50);
    add("pulseend",  7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h104, 2'b10, 32'h50);
    add("capt302",   7'b1_1_1_0_1_0_0, 32'h0,   32'h302, 32'h104, 2'b10, 32'h50);
    add("apply302",  7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h100, 2'b11, 32'h104);
    add("seq104",    7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h104, 2'b10, 32'h104);
    add("br201",     7'b1_0_1_0_1_0_0, 32'h0,   32'h201, 32'h100, 2'b11, 32'h104);
    add("capt203",   7'b1_1_1_1_0_0_0, 32'h203, 32'h0,   32'h100, 2'b10, 32'h104);
    add("nrdy",      7'b1_0_0_0_0_0_0, 32'h0,   32'h0,   32'h100, 2'b10, 32'h104);
    add("apply203",  7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h100, 2'b11, 32'h100);
    add("seq104b",   7'b1_0_1_0_0_0_0, 32'h0,   32'h0,   32'h104, 2'b10, 32'h100);
    add("jmpokbr",   7'b1_0_1_1_1_0_0, 32'h300, 32'h202, 32'h300, 2'b10, 32'h100);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (pc_curr !== e.pc) begin errors++; $display("[TB] FAIL %s pc_curr got %h expected %h", e.tag, pc_curr, e.pc); end
      checks++; if (misalign_fault !== e.flags[0]) begin errors++; $display("[TB] FAIL %s misalign_fault got %b expected %b", e.tag, misalign_fault, e.flags[0]); end
      checks++; if (epc !== e.epc) begin errors++; $display("[TB] FAIL %s epc got %h expected %h", e.tag, epc, e.epc); end
    end
  endtask

  task automatic test_wrap_and_reset();
    stim_t s;
    exp_t  e;
    add("jmpF8",     7'b1_0_1_1_0_0_0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 2'b10, 32'h100);
    add("seqFC",     7'b1_0_1_0_0_0_0, 32'h0,         32'h0, 32'hFFFF_FFFC, 2'b10, 32'h100);
    add("wrap0",     7'b1_0_1_0_0_0_0, 32'h0,         32'h0, 32'h0,         2'b10, 32'h100);
    add("seq4",      7'b1_0_1_0_0_0_0, 32'h0,         32'h0, 32'h4,         2'b10, 32'h100);
    add("capt700",   7'b1_1_1_1_0_0_0, 32'h700,       32'h0, 32'h4,         2'b10, 32'h100);
    add("rstpend",   7'b0_1_1_0_0_0_0, 32'h0,         32'h0, 32'h0,         2'b00, 32'h0);
    add("boottrap",  7'b1_0_1_0_0_1_0, 32'h0,         32'h0, 32'h0,         2'b10, 32'h0);
    add("buflost",   7'b1_0_1_0_0_0_0, 32'h0,         32'h0, 32'h4,         2'b10, 32'h0);
    add("seq8",      7'b1_0_1_0_0_0_0, 32'h0,         32'h0, 32'h8,         2'b10, 32'h0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive(s);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++; if (pc_curr !== e.pc) begin errors++; $display("[TB] FAIL %s pc_curr got %h expected %h", e.tag, pc_curr, e.pc); end
      checks++; if (pc_plus4 !== e.pc + 32'd4) begin errors++; $display("[TB] FAIL %s pc_plus4 got %h expected %h", e.tag, pc_plus4, e.pc + 32'd4); end
      checks++; if (fetch_valid !== e.flags[1]) begin errors++; $display("[TB] FAIL %s fetch_valid got %b expected %b", e.tag, fetch_valid, e.flags[1]); end
      checks++; if (misalign_fault !== e.flags[0]) begin errors++; $display("[TB] FAIL %s misalign_fault got %b expected %b", e.tag, misalign_fault, e.flags[0]); end
      checks++; if (epc !== e.epc) begin errors++; $display("[TB] FAIL %s epc got %h expected %h", e.tag, epc, e.epc); end
    end
  endtask

  // Scenario sequence; each one starts from where the previous one left off.
  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    fetch_ready   = 1'b1;
    jump          = 1'b0;
    PCSrc         = 1'b0;
    trap_req      = 1'b0;
    mret          = 1'b0;
    jump_target   = 32'h0;
    branch_target = 32'h0;
    #1;
    test_reset();
    test_redirect();
    test_pending();
    test_trap_mret();
    test_misalign();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
